axis_weight_pixel_join: RTL and testbench
=========================================

Name: axis_weight_pixel_join

Overview:
- Sits directly downstream of the weight rotator and upstream of the PE array.
- Joins the rotator's weight stream (tdata + tuser) with the pixel stream into a single AXIS beat per array clock.
- Config beats flagged in tuser pass alone without consuming pixels; all other beats require both inputs.
- Adds a registered skid-buffer output to break the combinational ready path, and checks config/data framing.

Parameters:
- COLS, `COLS, weight words per beat
- ROWS, `ROWS, pixel words per beat
- WORD_WIDTH, `WORD_WIDTH, bits per word
- TUSER_WIDTH, $bits(tuser_st), width of flattened weight tuser
- CONFIG_BIT, 0, index of is_config inside tuser
- CONFIG_BEATS, `CONFIG_BEATS, config beats expected at start of every weight packet

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_w_tvalid  in  1  weight valid
- s_w_tready  out  1  weight ready
- s_w_tlast  in  1  weight packet last
- s_w_tdata  in  COLS*WORD_WIDTH  weights
- s_w_tuser  in  TUSER_WIDTH  weight sideband
- s_x_tvalid  in  1  pixel valid
- s_x_tready  out  1  pixel ready
- s_x_tdata  in  ROWS*WORD_WIDTH  pixels
- m_tvalid  out  1  joined valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  copy of weight tlast
- m_tdata_w  out  COLS*WORD_WIDTH  weights
- m_tdata_x  out  ROWS*WORD_WIDTH  pixels (zero on config beats)
- m_tuser  out  TUSER_WIDTH  copy of weight tuser
- err_framing  out  1  sticky framing error

Behaviour:
- Reset (async assert, sync deassert internally):
  - m_tvalid=0, m_tlast=0, data outputs 0, err_framing=0, skid empty, state=S_CONFIG, cfg_cnt=0.
- Join rule:
  - cfg = s_w_tuser[CONFIG_BIT].
  - Input fires when s_w_tvalid && (cfg || s_x_tvalid) && skid_not_full.
  - s_w_tready = skid_not_full && (cfg || s_x_tvalid).
  - s_x_tready = skid_not_full && s_w_tvalid && !cfg.
  - No combinational path from m_tready to either s_*_tready; readys depend only on registered skid occupancy.
- Skid buffer:
  - 2 entries (main + skid register); latency 1 cycle from input fire to m_tvalid.
  - Sustains 1 beat/clk with m_tready=1.
  - When m_tready drops, at most one extra beat is absorbed, then readys deassert next cycle.
  - Simultaneous push and pop when full-minus-one: occupancy unchanged, order preserved.
- FSM:
  - S_CONFIG: each fired beat increments cfg_cnt.
    - Non-config beat while cfg_cnt<CONFIG_BEATS sets err_framing; the beat still passes.
    - When cfg_cnt reaches CONFIG_BEATS-1 on a config fire -> S_DATA.
    - tlast in S_CONFIG sets err_framing and goes to S_CONFIG with cfg_cnt=0.
  - S_DATA: a config beat sets err_framing, the beat still passes. Fired beat with s_w_tlast -> S_CONFIG, cfg_cnt=0.
- err_framing is sticky until reset.
- Counter cfg_cnt width $clog2(CONFIG_BEATS+1); never wraps (saturates).
- m_tdata_x forced to 0 on config beats.
- No pixel is ever consumed without a weight beat.
- Reset mid-packet: everything returns to reset state, the in-flight skid contents are dropped, and readys are 0 while aresetn=0.

Optional Feature:
- Macro: AXIS_WEIGHT_PIXEL_JOIN_STATS_EN.
- When defined, adds outputs stat_beats[31:0] (fired data beats), stat_cfg[31:0] (fired config beats), stat_stall_x[31:0] (cycles s_w_tvalid && !cfg && !s_x_tvalid) and stat_stall_m[31:0] (cycles m_tvalid && !m_tready).
- All four counters wrap at 2^32 and are cleared by reset.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Setup for all scenarios: CONFIG_BEATS=2.
- Happy path:
  - Stimulus: 2 config beats, 6 data beats with tlast on the 6th; pixels always valid; m_tready=1.
  - Response: 8 output beats at 1/clk after 1-cycle latency; exactly 6 pixels consumed; m_tdata_x=0 on the first 2; err_framing=0.
- Config bypass:
  - Stimulus: s_x_tvalid=0 throughout the config beats.
  - Response: both config beats emitted; s_x_tready never high; the stream then stalls at the first data beat until s_x_tvalid rises.
- Backpressure:
  - Stimulus: m_tready low for 5 cycles mid-packet.
  - Response: occupancy reaches 2; readys low the next cycle; no beat lost or duplicated; order intact on resume.
- Framing errors:
  - Stimulus: a data beat arriving as the second beat in S_CONFIG.
  - Response: err_framing=1, the beat is passed, and err_framing stays 1 through subsequent packets.
- Reset mid-packet:
  - Stimulus: assert aresetn=0 asynchronously during S_DATA with the skid full.
  - Response: m_tvalid drops immediately; after release, a fresh 2-config packet is accepted correctly.
- Stats (with AXIS_WEIGHT_PIXEL_JOIN_STATS_EN defined):
  - Stimulus: the happy-path packet repeated 3 times.
  - Response: stat_beats=18, stat_cfg=6.

Source files
------------

// File: rtl/axis_weight_pixel_join_if.sv
// -----------------------------------------------------------------------------
// axis_weight_pixel_join_if
// Bundles the weight stream, the pixel stream, the joined output stream and
// the framing error flag of axis_weight_pixel_join.
//   master : upstream sources plus downstream sink (drives valids/data and
//            m_tready, observes readys and the joined beat)
//   slave  : the join block itself
// Signals:
//   s_w_*  weight stream in  (tvalid/tready/tlast/tdata/tuser)
//   s_x_*  pixel stream in   (tvalid/tready/tdata)
//   m_*    joined stream out (tvalid/tready/tlast/tdata_w/tdata_x/tuser)
//   err_framing  sticky config/data framing error
// -----------------------------------------------------------------------------
interface axis_weight_pixel_join_if #(
  parameter int COLS        = 2,
  parameter int ROWS        = 2,
  parameter int WORD_WIDTH  = 8,
  parameter int TUSER_WIDTH = 4
);
  logic                        s_w_tvalid;
  logic                        s_w_tready;
  logic                        s_w_tlast;
  logic [COLS*WORD_WIDTH-1:0]  s_w_tdata;
  logic [TUSER_WIDTH-1:0]      s_w_tuser;
  logic                        s_x_tvalid;
  logic                        s_x_tready;
  logic [ROWS*WORD_WIDTH-1:0]  s_x_tdata;
  logic                        m_tvalid;
  logic                        m_tready;
  logic                        m_tlast;
  logic [COLS*WORD_WIDTH-1:0]  m_tdata_w;
  logic [ROWS*WORD_WIDTH-1:0]  m_tdata_x;
  logic [TUSER_WIDTH-1:0]      m_tuser;
  logic                        err_framing;

  modport master (
    output s_w_tvalid, s_w_tlast, s_w_tdata, s_w_tuser,
    output s_x_tvalid, s_x_tdata, m_tready,
    input  s_w_tready, s_x_tready,
    input  m_tvalid, m_tlast, m_tdata_w, m_tdata_x, m_tuser, err_framing
  );

  modport slave (
    input  s_w_tvalid, s_w_tlast, s_w_tdata, s_w_tuser,
    input  s_x_tvalid, s_x_tdata, m_tready,
    output s_w_tready, s_x_tready,
    output m_tvalid, m_tlast, m_tdata_w, m_tdata_x, m_tuser, err_framing
  );
endinterface

// File: rtl/axis_weight_pixel_join.sv
// -----------------------------------------------------------------------------
// axis_weight_pixel_join
// Joins the weight rotator stream with the pixel stream into one AXIS beat for
// the PE array. Config beats (tuser[CONFIG_BIT]=1) pass alone and never take a
// pixel; every other beat needs both a weight and a pixel. The output is a
// two-entry skid buffer so input readys come only from registered occupancy.
// A small FSM checks that each weight packet opens with CONFIG_BEATS config
// beats and sets a sticky err_framing otherwise.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   bus (slave)   : weight in, pixel in, joined out, err_framing
//   stat_*        : beat/stall counters (only with the macro below)
// Optional feature macro: AXIS_WEIGHT_PIXEL_JOIN_STATS_EN
// -----------------------------------------------------------------------------
module axis_weight_pixel_join #(
  parameter int COLS         = 2,
  parameter int ROWS         = 2,
  parameter int WORD_WIDTH   = 8,
  parameter int TUSER_WIDTH  = 4,
  parameter int CONFIG_BIT   = 0,
  parameter int CONFIG_BEATS = 2
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axis_weight_pixel_join_if.slave bus
`ifdef AXIS_WEIGHT_PIXEL_JOIN_STATS_EN
  ,
  output logic [31:0]            stat_beats,
  output logic [31:0]            stat_cfg,
  output logic [31:0]            stat_stall_x,
  output logic [31:0]            stat_stall_m
`endif
);
  localparam int WW = COLS*WORD_WIDTH;
  localparam int XW = ROWS*WORD_WIDTH;
  localparam int CW = $clog2(CONFIG_BEATS+1);
  localparam logic [CW-1:0] CB  = CW'(CONFIG_BEATS);
  localparam logic [CW-1:0] CB1 = CW'(CONFIG_BEATS-1);

  typedef enum logic {S_CONFIG, S_DATA} state_t;

  logic                   r_en;
  logic                   r_m_vld, r_m_last;
  logic [WW-1:0]          r_m_w;
  logic [XW-1:0]          r_m_x;
  logic [TUSER_WIDTH-1:0] r_m_user;
  logic                   r_s_vld, r_s_last;
  logic [WW-1:0]          r_s_w;
  logic [XW-1:0]          r_s_x;
  logic [TUSER_WIDTH-1:0] r_s_user;
  state_t                 r_state;
  logic [CW-1:0]          r_cfg_cnt;
  logic                   r_err;

  logic          w_cfg, w_not_full, w_fire, w_pop;
  logic [XW-1:0] w_x_in;

  assign w_cfg      = bus.s_w_tuser[CONFIG_BIT];
  // r_en stays low through reset and the first edge after release, so the
  // readys are 0 during reset and come up synchronously afterwards.
  assign w_not_full = r_en && !r_s_vld;
  assign w_fire     = bus.s_w_tvalid && (w_cfg || bus.s_x_tvalid) && w_not_full;
  assign w_pop      = r_m_vld && bus.m_tready;
  assign w_x_in     = w_cfg ? '0 : bus.s_x_tdata;

  assign bus.s_w_tready  = w_not_full && (w_cfg || bus.s_x_tvalid);
  assign bus.s_x_tready  = w_not_full && bus.s_w_tvalid && !w_cfg;
  assign bus.m_tvalid    = r_m_vld;
  assign bus.m_tlast     = r_m_last;
  assign bus.m_tdata_w   = r_m_w;
  assign bus.m_tdata_x   = r_m_x;
  assign bus.m_tuser     = r_m_user;
  assign bus.err_framing = r_err;

  // Skid buffer: main register feeds the output, skid register catches the
  // one beat accepted while the output is stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_en     <= 1'b0;
      r_m_vld  <= 1'b0;
      r_m_last <= 1'b0;
      r_m_w    <= '0;
      r_m_x    <= '0;
      r_m_user <= '0;
      r_s_vld  <= 1'b0;
      r_s_last <= 1'b0;
      r_s_w    <= '0;
      r_s_x    <= '0;
      r_s_user <= '0;
    end else begin
      r_en <= 1'b1;
      if (w_pop) begin
        if (r_s_vld) begin
          // Skid full means no push this cycle; promote skid to main.
          r_m_last <= r_s_last;
          r_m_w    <= r_s_w;
          r_m_x    <= r_s_x;
          r_m_user <= r_s_user;
          r_s_vld  <= 1'b0;
        end else if (w_fire) begin
          r_m_last <= bus.s_w_tlast;
          r_m_w    <= bus.s_w_tdata;
          r_m_x    <= w_x_in;
          r_m_user <= bus.s_w_tuser;
        end else begin
          r_m_vld  <= 1'b0;
        end
      end else if (w_fire) begin
        if (!r_m_vld) begin
          r_m_vld  <= 1'b1;
          r_m_last <= bus.s_w_tlast;
          r_m_w    <= bus.s_w_tdata;
          r_m_x    <= w_x_in;
          r_m_user <= bus.s_w_tuser;
        end else begin
          r_s_vld  <= 1'b1;
          r_s_last <= bus.s_w_tlast;
          r_s_w    <= bus.s_w_tdata;
          r_s_x    <= w_x_in;
          r_s_user <= bus.s_w_tuser;
        end
      end
    end
  end

  // Framing checker: beats always pass, violations only raise err_framing.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_CONFIG;
      r_cfg_cnt <= '0;
      r_err     <= 1'b0;
    end else if (w_fire) begin
      case (r_state)
        S_CONFIG: begin
          if (bus.s_w_tlast) begin
            r_err     <= 1'b1;
            r_cfg_cnt <= '0;
          end else begin
            if (!w_cfg && (r_cfg_cnt < CB)) r_err <= 1'b1;
            if (r_cfg_cnt != CB) r_cfg_cnt <= r_cfg_cnt + CW'(1);
            if (w_cfg && (r_cfg_cnt >= CB1)) r_state <= S_DATA;
          end
        end
        default: begin
          if (w_cfg) r_err <= 1'b1;
          if (bus.s_w_tlast) begin
            r_state   <= S_CONFIG;
            r_cfg_cnt <= '0;
          end
        end
      endcase
    end
  end

`ifdef AXIS_WEIGHT_PIXEL_JOIN_STATS_EN
  logic [31:0] r_stat_beats, r_stat_cfg, r_stat_stall_x, r_stat_stall_m;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_stat_beats   <= '0;
      r_stat_cfg     <= '0;
      r_stat_stall_x <= '0;
      r_stat_stall_m <= '0;
    end else begin
      if (w_fire && !w_cfg) r_stat_beats <= r_stat_beats + 32'd1;
      if (w_fire && w_cfg)  r_stat_cfg   <= r_stat_cfg + 32'd1;
      if (bus.s_w_tvalid && !w_cfg && !bus.s_x_tvalid)
        r_stat_stall_x <= r_stat_stall_x + 32'd1;
      if (r_m_vld && !bus.m_tready)
        r_stat_stall_m <= r_stat_stall_m + 32'd1;
    end
  end

  assign stat_beats   = r_stat_beats;
  assign stat_cfg     = r_stat_cfg;
  assign stat_stall_x = r_stat_stall_x;
  assign stat_stall_m = r_stat_stall_m;
`endif
endmodule

// File: tb/tb_axis_weight_pixel_join.sv
// -----------------------------------------------------------------------------
// tb_axis_weight_pixel_join
// Directed bench for axis_weight_pixel_join with CONFIG_BEATS=2, 16-bit
// weight/pixel beats and 4-bit tuser (bit 0 = is_config). Beat k carries
// weight 16'hA000+k, pixel 16'hB000+k and tuser {k[2:0], is_config}.
// -----------------------------------------------------------------------------
module tb_axis_weight_pixel_join;
  logic aclk;
  logic aresetn;

  axis_weight_pixel_join_if #(.COLS(2), .ROWS(2), .WORD_WIDTH(8), .TUSER_WIDTH(4)) bus ();

`ifdef AXIS_WEIGHT_PIXEL_JOIN_STATS_EN
  logic [31:0] stat_beats, stat_cfg, stat_stall_x, stat_stall_m;
`endif

  axis_weight_pixel_join #(
    .COLS(2), .ROWS(2), .WORD_WIDTH(8), .TUSER_WIDTH(4),
    .CONFIG_BIT(0), .CONFIG_BEATS(2)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
`ifdef AXIS_WEIGHT_PIXEL_JOIN_STATS_EN
    ,
    .stat_beats   (stat_beats),
    .stat_cfg     (stat_cfg),
    .stat_stall_x (stat_stall_x),
    .stat_stall_m (stat_stall_m)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [15:0] out_w[$];
  logic [15:0] out_x[$];
  logic [3:0]  out_user[$];
  logic        out_last[$];
  int          out_cyc[$];
  int          in_cyc[$];
  int          x_cnt;
  bit          x_rdy_seen;

  always @(posedge aclk) cyc <= cyc + 1;

  // Observe handshakes mid-cycle; inputs only change just after posedge.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (bus.m_tvalid && bus.m_tready) begin
        out_w.push_back(bus.m_tdata_w);
        out_x.push_back(bus.m_tdata_x);
        out_user.push_back(bus.m_tuser);
        out_last.push_back(bus.m_tlast);
        out_cyc.push_back(cyc);
      end
      if (bus.s_w_tvalid && bus.s_w_tready) in_cyc.push_back(cyc);
      if (bus.s_x_tvalid && bus.s_x_tready) x_cnt++;
      if (bus.s_x_tready) x_rdy_seen = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    out_w.delete(); out_x.delete(); out_user.delete();
    out_last.delete(); out_cyc.delete(); in_cyc.delete();
    x_cnt = 0;
  endtask

  task automatic drive(input int k, input bit c, input bit last, input bit xv);
    bus.s_w_tvalid = 1'b1;
    bus.s_w_tdata  = 16'hA000 + 16'(k);
    bus.s_w_tuser  = {3'(k), c};
    bus.s_w_tlast  = last;
    bus.s_x_tdata  = 16'hB000 + 16'(k);
    bus.s_x_tvalid = xv;
  endtask

  task automatic beat(input int k, input bit c, input bit last, input bit xv);
    bit done;
    drive(k, c, last, xv);
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge aclk);
      if (bus.s_w_tvalid && bus.s_w_tready) done = 1'b1;
      @(posedge aclk); #1;
    end
    chk($sformatf("fire_%0h", k), 32'(done), 32'd1);
    bus.s_w_tvalid = 1'b0;
    bus.s_x_tvalid = 1'b0;
    bus.s_w_tlast  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int i, input int k, input bit c, input bit last);
    if (i < out_w.size()) begin
      chk($sformatf("%s_w%0d", tag, i), 32'(out_w[i]), 32'(16'hA000 + 16'(k)));
      chk($sformatf("%s_x%0d", tag, i), 32'(out_x[i]), c ? 32'd0 : 32'(16'hB000 + 16'(k)));
      chk($sformatf("%s_u%0d", tag, i), 32'(out_user[i]), 32'({3'(k), c}));
      chk($sformatf("%s_l%0d", tag, i), 32'(out_last[i]), 32'(last));
    end else begin
      chk($sformatf("%s_missing%0d", tag, i), 32'(out_w.size()), 32'(i + 1));
    end
  endtask

  task automatic drain();
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;
  endtask

  task automatic happy_packet(input int base);
    beat(base, 1'b1, 1'b0, 1'b1);
    beat(base + 1, 1'b1, 1'b0, 1'b1);
    for (int k = 2; k < 8; k++) beat(base + k, 1'b0, k == 7, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    aresetn = 1'b0;
    bus.m_tready = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b1);
    #12;
    // Reset state, with valid inputs presented
    chk("rst_m_tvalid",  32'(bus.m_tvalid), 32'd0);
    chk("rst_m_tlast",   32'(bus.m_tlast), 32'd0);
    chk("rst_m_tdata_w", 32'(bus.m_tdata_w), 32'd0);
    chk("rst_m_tdata_x", 32'(bus.m_tdata_x), 32'd0);
    chk("rst_err",       32'(bus.err_framing), 32'd0);
    chk("rst_w_tready",  32'(bus.s_w_tready), 32'd0);
    chk("rst_x_tready",  32'(bus.s_x_tready), 32'd0);
    bus.s_w_tvalid = 1'b0;
    bus.s_x_tvalid = 1'b0;
    bus.s_w_tlast  = 1'b0;
    @(posedge aclk); #3 aresetn = 1'b1;

    // Happy path
    clear_log();
    happy_packet(0);
    drain();
    chk("hp_count", 32'(out_w.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk_out("hp", i, i, i < 2, i == 7);
    chk("hp_pixels", 32'(x_cnt), 32'd6);
    chk("hp_err", 32'(bus.err_framing), 32'd0);
    if (out_cyc.size() == 8 && in_cyc.size() == 8) begin
      chk("hp_latency", 32'(out_cyc[0]), 32'(in_cyc[0] + 1));
      chk("hp_out_rate", 32'(out_cyc[7]), 32'(out_cyc[0] + 7));
      chk("hp_in_rate", 32'(in_cyc[7]), 32'(in_cyc[0] + 7));
    end else begin
      chk("hp_cyc_log", 32'(in_cyc.size()), 32'd8);
    end

    // Config bypass with no pixels available
    clear_log();
    x_rdy_seen = 1'b0;
    beat(16'h10, 1'b1, 1'b0, 1'b0);
    beat(16'h11, 1'b1, 1'b0, 1'b0);
    chk("cb_x_ready_seen", 32'(x_rdy_seen), 32'd0);
    drive(16'h12, 1'b0, 1'b0, 1'b0);
    repeat (4) begin @(negedge aclk); @(posedge aclk); #1; end
    @(negedge aclk);
    chk("cb_stall_w_ready", 32'(bus.s_w_tready), 32'd0);
    chk("cb_cfg_emitted", 32'(out_w.size()), 32'd2);
    chk("cb_no_pixel", 32'(x_cnt), 32'd0);
    @(posedge aclk); #1;
    beat(16'h12, 1'b0, 1'b0, 1'b1);
    beat(16'h13, 1'b0, 1'b1, 1'b1);
    drain();
    chk("cb_count", 32'(out_w.size()), 32'd4);
    chk_out("cb", 0, 16'h10, 1'b1, 1'b0);
    chk_out("cb", 2, 16'h12, 1'b0, 1'b0);
    chk_out("cb", 3, 16'h13, 1'b0, 1'b1);
    chk("cb_pixels", 32'(x_cnt), 32'd2);

    // Backpressure: m_tready low for 5 cycles mid-packet
    clear_log();
    beat(16'h20, 1'b1, 1'b0, 1'b1);
    beat(16'h21, 1'b1, 1'b0, 1'b1);
    beat(16'h22, 1'b0, 1'b0, 1'b1);
    bus.m_tready = 1'b0;
    beat(16'h23, 1'b0, 1'b0, 1'b1);
    drive(16'h24, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      chk($sformatf("bp_w_ready%0d", c), 32'(bus.s_w_tready), 32'd0);
      chk($sformatf("bp_x_ready%0d", c), 32'(bus.s_x_tready), 32'd0);
      chk($sformatf("bp_hold%0d", c), 32'(bus.m_tdata_w), 32'h0000A022);
      @(posedge aclk); #1;
    end
    bus.m_tready = 1'b1;
    beat(16'h24, 1'b0, 1'b0, 1'b1);
    beat(16'h25, 1'b0, 1'b0, 1'b1);
    beat(16'h26, 1'b0, 1'b0, 1'b1);
    beat(16'h27, 1'b0, 1'b1, 1'b1);
    drain();
    chk("bp_count", 32'(out_w.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk_out("bp", i, 16'h20 + i, i < 2, i == 7);
    chk("bp_pixels", 32'(x_cnt), 32'd6);
    chk("bp_err", 32'(bus.err_framing), 32'd0);

    // Framing error: data beat as second beat of the config phase
    clear_log();
    beat(16'h30, 1'b1, 1'b0, 1'b1);
    chk("fe_err_before", 32'(bus.err_framing), 32'd0);
    beat(16'h31, 1'b0, 1'b0, 1'b1);
    chk("fe_err_set", 32'(bus.err_framing), 32'd1);
    beat(16'h32, 1'b0, 1'b1, 1'b1);
    beat(16'h33, 1'b1, 1'b0, 1'b1);
    beat(16'h34, 1'b1, 1'b0, 1'b1);
    beat(16'h35, 1'b0, 1'b1, 1'b1);
    drain();
    chk("fe_count", 32'(out_w.size()), 32'd6);
    chk_out("fe", 1, 16'h31, 1'b0, 1'b0);
    chk_out("fe", 5, 16'h35, 1'b0, 1'b1);
    chk("fe_pixels", 32'(x_cnt), 32'd3);
    chk("fe_err_sticky", 32'(bus.err_framing), 32'd1);

    // Reset mid-packet with the skid full
    clear_log();
    beat(16'h40, 1'b1, 1'b0, 1'b1);
    beat(16'h41, 1'b1, 1'b0, 1'b1);
    beat(16'h42, 1'b0, 1'b0, 1'b1);
    bus.m_tready = 1'b0;
    beat(16'h43, 1'b0, 1'b0, 1'b1);
    drive(16'h44, 1'b1, 1'b0, 1'b1);
    @(negedge aclk);
    chk("rm_full_vld", 32'(bus.m_tvalid), 32'd1);
    chk("rm_full_ready", 32'(bus.s_w_tready), 32'd0);
    #2 aresetn = 1'b0;
    #1;
    chk("rm_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("rm_w_tready", 32'(bus.s_w_tready), 32'd0);
    chk("rm_x_tready", 32'(bus.s_x_tready), 32'd0);
    chk("rm_err", 32'(bus.err_framing), 32'd0);
    bus.s_w_tvalid = 1'b0;
    bus.s_x_tvalid = 1'b0;
    bus.m_tready   = 1'b1;
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;
    clear_log();
    beat(16'h50, 1'b1, 1'b0, 1'b1);
    beat(16'h51, 1'b1, 1'b0, 1'b1);
    beat(16'h52, 1'b0, 1'b0, 1'b1);
    beat(16'h53, 1'b0, 1'b1, 1'b1);
    drain();
    chk("rm_count", 32'(out_w.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_out("rm", i, 16'h50 + i, i < 2, i == 3);
    chk("rm_pixels", 32'(x_cnt), 32'd2);
    chk("rm_err_after", 32'(bus.err_framing), 32'd0);

`ifdef AXIS_WEIGHT_PIXEL_JOIN_STATS_EN
    // Stats: three happy-path packets after a fresh reset
    do_reset();
    chk("st_beats_rst", stat_beats, 32'd0);
    happy_packet(16'h60);
    happy_packet(16'h68);
    happy_packet(16'h70);
    drain();
    chk("st_beats", stat_beats, 32'd18);
    chk("st_cfg", stat_cfg, 32'd6);
    chk("st_stall_m", stat_stall_m, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
